// File: rtl/mips_muldiv_alu_if.sv
// Execute-stage request/result bundle for mips_muldiv_alu.
// The master issues operations; the slave (the ALU) returns registered results.
interface mips_muldiv_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             of;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, y, zero, of
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, y, zero, of
    );
endinterface

// File: rtl/mips_muldiv_alu.sv
// Registered MIPS ALU with single-cycle logic/arith ops and iterative
// shift-add multiply / restoring divide into HI/LO.
module mips_muldiv_alu #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mips_muldiv_alu_if.slave  bus
);
    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_ma, r_mb, r_a;
    logic [WIDTH-1:0] r_phi, r_plo;
    logic [WIDTH-1:0] r_hi, r_lo, r_y;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz, r_ovf;
    logic             r_zero, r_of, r_vld;

    // Returns {of, y} for every op that completes on the accept edge.
    function automatic logic [WIDTH:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic [WIDTH-1:0] sum, diff;
        logic             add_of, sub_of;
        sum    = a + b;
        diff   = a - b;
        add_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {add_of, sum};
            4'd3:    return {{WIDTH{1'b0}}, (a < b)};
            4'd4:    return {1'b0, a & ~b};
            4'd5:    return {1'b0, a | ~b};
            4'd6:    return {sub_of, diff};
            4'd7:    return {{WIDTH{1'b0}}, diff[WIDTH-1] ^ sub_of};
            4'd12:   return {1'b0, hi};
            4'd13:   return {1'b0, lo};
            default: return '0;
        endcase
    endfunction

    logic             w_muldiv, w_div, w_signed_op, w_sa, w_sb;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_alu;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rsh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quo, w_rem, w_fhi, w_flo;
    logic             w_fof;

    assign w_muldiv    = (bus.op[3:2] == 2'b10);
    assign w_div       = bus.op[1];
    assign w_signed_op = ~bus.op[0];
    assign w_sa        = w_signed_op & bus.a[WIDTH-1];
    assign w_sb        = w_signed_op & bus.b[WIDTH-1];
    assign w_mag_a     = w_sa ? -bus.a : bus.a;
    assign w_mag_b     = w_sb ? -bus.b : bus.b;
    assign w_alu       = alu_single(bus.op, bus.a, bus.b, r_hi, r_lo);

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    assign w_sum = {1'b0, r_phi} + (r_plo[0] ? {1'b0, r_ma} : '0);

    // Divide step: shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_rsh = {r_phi, r_plo[WIDTH-1]};
    assign w_ge  = (w_rsh >= {1'b0, r_mb});
    assign w_sub = w_rsh[WIDTH-1:0] - r_mb;

    assign w_prod   = {r_phi, r_plo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_plo : r_plo;
    assign w_rem    = r_neg_r ? -r_phi : r_phi;

    always_comb begin
        w_fhi = w_prod_s[2*WIDTH-1:WIDTH];
        w_flo = w_prod_s[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_fhi = r_a;
                w_flo = '1;
            end else begin
                w_fhi = w_rem;
                w_flo = w_quo;
            end
        end
    end

    // Most-negative / -1 already yields LO=MIN, HI=0 from the magnitude path; only the flag is extra.
    assign w_fof = r_is_div & (r_dz | r_ovf);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_y     <= '0;
            r_zero  <= 1'b1;
            r_of    <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_muldiv) begin
                            r_ma     <= w_mag_a;
                            r_mb     <= w_mag_b;
                            r_a      <= bus.a;
                            r_phi    <= '0;
                            r_plo    <= w_div ? w_mag_a : w_mag_b;
                            r_is_div <= w_div;
                            r_neg_q  <= w_sa ^ w_sb;
                            r_neg_r  <= w_sa;
                            r_dz     <= (bus.b == '0);
                            r_ovf    <= w_signed_op && (bus.a == MIN) && (bus.b == '1);
                            r_cnt    <= '0;
                            r_state  <= ITER;
                        end else begin
                            r_y    <= w_alu[WIDTH-1:0];
                            r_of   <= w_alu[WIDTH];
                            r_zero <= (w_alu[WIDTH-1:0] == '0);
                            r_vld  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (r_is_div) begin
                        r_phi <= w_ge ? w_sub : w_rsh[WIDTH-1:0];
                        r_plo <= {r_plo[WIDTH-2:0], w_ge};
                    end else begin
                        r_phi <= w_sum[WIDTH:1];
                        r_plo <= {w_sum[0], r_plo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST)
                        r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= w_fhi;
                    r_lo    <= w_flo;
                    r_y     <= w_flo;
                    r_zero  <= (w_flo == '0);
                    r_of    <= w_fof;
                    r_vld   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_vld;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.of        = r_of;
endmodule

// File: tb/tb_mips_muldiv_alu.sv
// Directed and randomized bench for mips_muldiv_alu against an arithmetic
// reference model of the ALU, HI/LO and handshake timing.
module tb_mips_muldiv_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_muldiv_alu_if #(.WIDTH(W)) bus();
    mips_muldiv_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the op's meaning, updating the model HI/LO.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] y, output logic of, output int lat);
        longint          sa, sb, s, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        of = 1'b0;
        lat = 1;
        y = '0;
        case (op)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd2: begin
                s = sa + sb;
                y = a + b;
                of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: y = (a < b) ? 32'd1 : 32'd0;
            4'd4: y = a & ~b;
            4'd5: y = a | ~b;
            4'd6: begin
                s = sa - sb;
                y = a - b;
                of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7: y = (sa < sb) ? 32'd1 : 32'd0;
            4'd8, 4'd9: begin
                p = (op == 4'd8) ? 64'(sa * sb) : 64'(ua * ub);
                m_hi = p[63:32];
                m_lo = p[31:0];
                y = m_lo;
                lat = W + 2;
            end
            4'd10, 4'd11: begin
                if (b == '0) begin
                    m_lo = '1;
                    m_hi = a;
                    of = 1'b1;
                end else if (op == 4'd10) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    of = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    m_lo = uq[31:0];
                    m_hi = ur[31:0];
                end
                y = m_lo;
                lat = W + 2;
            end
            4'd12: y = m_hi;
            4'd13: y = m_lo;
            default: y = '0;
        endcase
    endfunction

    // Issue one op, wait for its result, compare value, flags, latency and busy span.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ey;
        logic         eof;
        int           elat, lat, busy, wt;
        model(op, a, b, ey, eof, elat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        wt = 0;
        while (!bus.in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        busy = 0;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".y"}, 64'(bus.y), 64'(ey));
        check({tag, ".of"}, 64'(bus.of), 64'(eof));
        check({tag, ".zero"}, 64'(bus.zero), 64'(ey == '0));
        if (elat > 1) begin
            check({tag, ".busy"}, 64'(busy), 64'(W + 1));
            check({tag, ".ready"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ey, ax, bx;
        logic         eof;
        int           elat, n, pulses;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst.ready", 64'(bus.in_ready), 64'd1);
        check("rst.vld", 64'(bus.out_valid), 64'd0);
        check("rst.y", 64'(bus.y), 64'd0);
        check("rst.zero", 64'(bus.zero), 64'd1);
        check("rst.of", 64'(bus.of), 64'd0);

        // Back-to-back ADD overflow then SUB to zero
        bus.in_valid = 1'b1;
        bus.op = 4'd2;
        bus.a = 32'h7FFF_FFFF;
        bus.b = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        check("add.vld", 64'(bus.out_valid), 64'd1);
        check("add.y", 64'(bus.y), 64'h8000_0000);
        check("add.of", 64'(bus.of), 64'd1);
        check("add.zero", 64'(bus.zero), 64'd0);
        bus.op = 4'd6;
        bus.a = 32'd5;
        bus.b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("sub.vld", 64'(bus.out_valid), 64'd1);
        check("sub.y", 64'(bus.y), 64'd0);
        check("sub.zero", 64'(bus.zero), 64'd1);
        check("sub.of", 64'(bus.of), 64'd0);
        @(negedge clk);
        check("idle.vld", 64'(bus.out_valid), 64'd0);

        run_op("slt", 4'd7, 32'h8000_0000, 32'd1);
        run_op("sltu", 4'd3, 32'h8000_0000, 32'd1);
        run_op("op14", 4'd14, 32'h1234_5678, 32'hFFFF_0000);
        run_op("mult", 4'd8, 32'hFFFF_FFFD, 32'd7);
        check("mult.lo", 64'(bus.y), 64'hFFFF_FFEB);
        run_op("mfhi", 4'd12, 32'd0, 32'd0);
        check("mfhi.val", 64'(bus.y), 64'hFFFF_FFFF);
        run_op("multu", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mfhi2", 4'd12, 32'd0, 32'd0);
        check("multu.hi", 64'(bus.y), 64'hFFFF_FFFE);
        run_op("div", 4'd10, 32'hFFFF_FFF9, 32'd2);
        run_op("mfhi3", 4'd12, 32'd0, 32'd0);
        run_op("divu0", 4'd11, 32'd7, 32'd0);
        run_op("mfhi4", 4'd12, 32'd0, 32'd0);
        run_op("divov", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mfhi5", 4'd12, 32'd0, 32'd0);
        run_op("div0s", 4'd10, 32'hFFFF_FF00, 32'd0);
        run_op("mfhi6", 4'd12, 32'd0, 32'd0);

        // Reset during a multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'd9;
        bus.a = 32'd3;
        bus.b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort.ready", 64'(bus.in_ready), 64'd1);
        check("abort.vld", 64'(bus.out_valid), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("abort.pulses", 64'(pulses), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run_op("abort.mflo", 4'd13, 32'd0, 32'd0);
        run_op("abort.mfhi", 4'd12, 32'd0, 32'd0);

        // AND held while DIV is busy
        model(4'd10, 32'hFFFF_FF9C, 32'd7, ey, eof, elat);
        ax = 32'hF0F0_1234;
        bx = 32'h0FF0_FF00;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'd10;
        bus.a = 32'hFFFF_FF9C;
        bus.b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.op = 4'd0;
        bus.a = ax;
        bus.b = bx;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold.lat", 64'(n), 64'(elat));
        check("hold.divy", 64'(bus.y), 64'(ey));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("hold.andvld", 64'(bus.out_valid), 64'd1);
        check("hold.andy", 64'(bus.y), 64'(ax & bx));
        run_op("hold.mfhi", 4'd12, 32'd0, 32'd0);
        run_op("hold.mflo", 4'd13, 32'd0, 32'd0);

        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_alu.md
Name: mips_muldiv_alu

Overview:
Parametrised, registered successor to the single-cycle MIPS ALU. Adds SLTU, iterative signed/unsigned multiply and divide, and HI/LO registers with MFHI/MFLO. Uses a valid/ready input handshake and a registered result with a one-cycle out_valid pulse. Sits in the execute stage; the pipeline stalls on in_ready low.

Parameters:
WIDTH, 32, datapath width in bits; must be even and at least 4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation; high exactly when FSM is IDLE
op  input  4  operation code (see Behaviour)
a  input  WIDTH  operand A (dividend / multiplicand)
b  input  WIDTH  operand B (divisor / multiplier)
out_valid  output  1  one-cycle pulse: y/zero/of hold a new result
y  output  WIDTH  registered result; holds until the next result
zero  output  1  registered, equals (y == 0)
of  output  1  registered overflow / exception flag

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: FSM IDLE; y=0; zero=1; of=0; out_valid=0; HI=0; LO=0.
- Accept on the rising edge where in_valid && in_ready. Inputs are ignored otherwise. No output backpressure.
- op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SLTU, 4 A&~B, 5 A|~B, 6 SUB, 7 SLT
  - 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO
  - 14 and 15: y=0, of=0
- Single-cycle ops (0-7, 12-15): the result registers on the accept edge, and out_valid is high the following cycle. FSM stays IDLE, giving back-to-back throughput of 1 op/cycle.
- ADD/SUB: y is WIDTH-bit wraparound.
  - ADD: of=1 when a and b have equal sign and the sum sign differs.
  - SUB: of=1 when a and b have opposite sign and the difference sign differs from a.
  - of=0 for all other single-cycle ops.
- SLT: y = {0..., sub_sign XOR sub_overflow} (signed a<b). SLTU: y = {0..., a<b unsigned}.
- MFHI/MFLO return the current HI/LO. HI/LO are unchanged by every op other than 8-11.
- Multi-cycle ops (8-11) use FSM IDLE -> ITER -> FIX -> IDLE.
  - Accept edge: latch the operand magnitudes (absolute values for signed ops) and the result signs, clear the iteration counter, enter ITER. in_ready goes low.
  - ITER: one radix-2 step per cycle for exactly WIDTH cycles. Multiply is shift-add into a 2*WIDTH product. Divide is restoring, producing one quotient bit per cycle.
  - FIX: apply sign correction, write HI/LO, register y=LO, set zero, set of, pulse out_valid on the next cycle, return to IDLE.
  - Latency: out_valid is high in the cycle WIDTH+2 edges after the accept edge. in_ready goes high in that same cycle.
- Multiply results: {HI,LO} = full 2*WIDTH product; of=0.
- Divide results: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend; of=0 for normal cases.
- Divide by zero (b==0, DIV or DIVU): LO=all ones, HI=a, of=1. Same latency, no early exit.
- Signed overflow (DIV with a=most-negative, b=-1): LO=most-negative, HI=0, of=1.
- in_valid while busy: not accepted; the requester must hold. The cycle in which in_ready returns high may accept a new op.
- Reset mid-operation: aborts the op. No out_valid is produced. HI/LO clear to 0. FSM is IDLE and in_ready is high in the cycle after the reset edge.
- Iteration counter is $clog2(WIDTH)+1 bits; no wraparound reuse.

Test Plan:
1. WIDTH=32, ADD a=0x7FFFFFFF b=0x00000001 -> next cycle out_valid=1, y=0x80000000, of=1, zero=0. Then SUB a=5 b=5 on the following cycle -> y=0, zero=1, of=0.
2. SLT a=0x80000000 b=1 -> y=1. SLTU, same operands -> y=0. op=14 -> y=0, of=0.
3. MULT a=0xFFFFFFFD (-3) b=7 -> in_ready low 33 cycles; out_valid 34 cycles after accept; y=LO=0xFFFFFFEB. Then MFHI -> 0xFFFFFFFF. MULTU 0xFFFFFFFF*0xFFFFFFFF -> LO=0x00000001, HI=0xFFFFFFFE.
4. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, of=0. DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=7, of=1. DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0, of=1.
5. MULTU 3*4 started; reset asserted on iteration 10 -> no out_valid ever pulses; in_ready=1 next cycle; MFLO returns 0, MFHI returns 0.
6. Issue AND while a DIV is busy with in_valid held -> AND is not accepted until the DIV out_valid cycle, then y=a&b one cycle later. HI/LO still hold the DIV results.
